// File: rtl/rr_hold_arb_pkg.sv
// rr_hold_arb_pkg
//   Shared types and helpers for the round-robin hold arbiter family.
//   - arb_state_e : arbiter FSM state encoding (IDLE, GRANT, GAP)
//   - width_of    : counter/index width helper, never returns less than 1
//   - onehot_to_idx : index of the set bit of a one-hot vector (0 if none)
package rr_hold_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_e;

   // Bits needed to hold values 0..v-1, minimum 1 bit.
   function automatic int width_of(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   localparam int ONEHOT_MAX = 64;

   function automatic int onehot_to_idx(input logic [ONEHOT_MAX-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < ONEHOT_MAX; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_hold_arb_pick.sv
// rr_pick
//   Combinational round-robin picker. Scans req starting at ptr and wrapping
//   modulo N; the first requester found wins.
//   Ports:
//     req        in  [N-1:0]    request vector
//     ptr        in  [IDW-1:0]  highest-priority channel
//     any        out            at least one request present
//     win_id     out [IDW-1:0]  encoded winner (0 when !any)
//     win_onehot out [N-1:0]    one-hot winner (0 when !any)
module rr_pick
   import rr_hold_arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = width_of(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic           any,
   output logic [IDW-1:0] win_id,
   output logic [N-1:0]   win_onehot
);

   logic           found;
   logic [IDW-1:0] idx;

   always_comb begin
      win_onehot = '0;
      found      = 1'b0;
      idx        = '0;
      for (int k = 0; k < N; k++) begin
         idx = IDW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            win_onehot[idx] = 1'b1;
            found           = 1'b1;
         end
      end
   end

   assign any    = |req;
   assign win_id = IDW'(onehot_to_idx(ONEHOT_MAX'(win_onehot)));

endmodule

// File: rtl/rr_hold_arb.sv
// rr_hold_arb
//   N-channel round-robin arbiter with bounded grant tenure (MAX_HOLD) and a
//   programmable idle gap (GAP_CYCLES) between grants.
//   Handshake: req[i] is a level held until served. A grant lasts until the
//   granted channel pulses done, drops req, or reaches MAX_HOLD cycles; done
//   and req on channels that are not granted are ignored while a grant runs.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     req, done   [N-1:0] per-channel request level / completion pulse
//     gnt         [N-1:0] registered one-hot grant
//     gnt_vld     registered OR of gnt
//     gnt_id      encoded granted channel, valid while gnt_vld
//     timeout     one-cycle pulse on the first idle cycle after a forced release
//     ptr         current highest-priority channel
module rr_hold_arb
   import rr_hold_arb_pkg::*;
#(
   parameter int N          = 4,
   parameter int MAX_HOLD   = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          req,
   input  logic [N-1:0]          done,
   output logic [N-1:0]          gnt,
   output logic                  gnt_vld,
   output logic [width_of(N)-1:0] gnt_id,
   output logic                  timeout,
   output logic [width_of(N)-1:0] ptr
);

   localparam int IDW = width_of(N);
   localparam int HCW = width_of(MAX_HOLD + 1);
   localparam int GCW = width_of(GAP_CYCLES + 1);

   arb_state_e     state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic           gnt_vld_q;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic           timeout_q, timeout_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
   logic [GCW-1:0] gap_cnt_q, gap_cnt_d;

   logic           do_arb;
   logic           forced;
   logic [IDW-1:0] next_ptr;
   logic [IDW-1:0] pick_ptr;
   logic           pick_any;
   logic [IDW-1:0] pick_id;
   logic [N-1:0]   pick_onehot;

   assign next_ptr = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);

   // During GRANT the only arbitration that can happen is the back-to-back
   // one on release, which must already see the advanced pointer so the
   // releasing channel drops to lowest priority.
   assign pick_ptr = (state_q == ST_GRANT) ? next_ptr : ptr_q;

   rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .req        (req),
      .ptr        (pick_ptr),
      .any        (pick_any),
      .win_id     (pick_id),
      .win_onehot (pick_onehot)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      timeout_d  = 1'b0;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      do_arb     = 1'b0;
      forced     = 1'b0;

      case (state_q)
         ST_IDLE: do_arb = 1'b1;

         ST_GRANT: begin
            // done wins over the hold limit, so a collision is a normal release.
            forced = !done[gnt_id_q] && req[gnt_id_q] &&
                     (hold_cnt_q == HCW'(MAX_HOLD));
            if (done[gnt_id_q] || !req[gnt_id_q] || forced) begin
               gnt_d      = '0;
               hold_cnt_d = '0;
               ptr_d      = next_ptr;
               timeout_d  = forced;
               if (GAP_CYCLES > 0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GCW'(GAP_CYCLES);
               end else if (forced) begin
                  // Keep one idle cycle so the timeout pulse never overlaps a grant.
                  state_d = ST_IDLE;
               end else begin
                  do_arb = 1'b1;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HCW'(1);
            end
         end

         ST_GAP: begin
            // Last gap cycle arbitrates directly so gnt is low exactly GAP_CYCLES cycles.
            if (gap_cnt_q <= GCW'(1)) do_arb = 1'b1;
            else                      gap_cnt_d = gap_cnt_q - GCW'(1);
         end

         default: state_d = ST_IDLE;
      endcase

      if (do_arb) begin
         gap_cnt_d = '0;
         if (pick_any) begin
            state_d    = ST_GRANT;
            gnt_d      = pick_onehot;
            gnt_id_d   = pick_id;
            hold_cnt_d = HCW'(1);
         end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         gnt_vld_q  <= 1'b0;
         gnt_id_q   <= '0;
         timeout_q  <= 1'b0;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_vld_q  <= |gnt_d;
         gnt_id_q   <= gnt_id_d;
         timeout_q  <= timeout_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_vld = gnt_vld_q;
   assign gnt_id  = gnt_id_q;
   assign timeout = timeout_q;
   assign ptr     = ptr_q;

endmodule

// File: tb/tb_rr_hold_arb.sv
// tb_rr_hold_arb
//   Directed table-driven bench for rr_hold_arb. dut_a uses the default
//   parameters (N=4, MAX_HOLD=8, GAP_CYCLES=1); dut_b uses GAP_CYCLES=0.
//   Each vector drives req/done before a rising edge and lists the outputs
//   expected just after that edge.
module tb_rr_hold_arb;

   logic       clk;
   logic       rst_n;
   logic [3:0] a_req, a_done, a_gnt, b_req, b_done, b_gnt;
   logic       a_vld, a_to, b_vld, b_to;
   logic [1:0] a_id, a_ptr, b_id, b_ptr;

   int total;
   int bad;

   typedef struct {
      bit         sel;       // 0 = dut_a, 1 = dut_b
      bit         rst;       // apply reset before this vector
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] exp_gnt;
      logic       exp_to;
      logic [1:0] exp_ptr;
   } vec_t;

   vec_t       tbl[$];
   logic [3:0] exp_q[$];

   rr_hold_arb #(.N(4), .MAX_HOLD(8), .GAP_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(a_req), .done(a_done),
      .gnt(a_gnt), .gnt_vld(a_vld), .gnt_id(a_id), .timeout(a_to), .ptr(a_ptr)
   );

   rr_hold_arb #(.N(4), .MAX_HOLD(8), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(b_req), .done(b_done),
      .gnt(b_gnt), .gnt_vld(b_vld), .gnt_id(b_id), .timeout(b_to), .ptr(b_ptr)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      a_req  = '0; a_done = '0; b_req = '0; b_done = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] idx_of(input logic [3:0] oh);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   function automatic void add(input bit sel, input bit rst, input logic [3:0] req,
                               input logic [3:0] done, input logic [3:0] g,
                               input logic to, input logic [1:0] p);
      vec_t v;
      v.sel = sel; v.rst = rst; v.req = req; v.done = done;
      v.exp_gnt = g; v.exp_to = to; v.exp_ptr = p;
      tbl.push_back(v);
   endfunction

   // driver
   task automatic step(input vec_t v, input int n);
      logic [3:0] g;
      logic [3:0] eg;
      logic       vl, to;
      logic [1:0] id, p;
      if (v.rst) do_reset();
      @(negedge clk);
      a_req  = v.sel ? 4'b0 : v.req;
      a_done = v.sel ? 4'b0 : v.done;
      b_req  = v.sel ? v.req  : 4'b0;
      b_done = v.sel ? v.done : 4'b0;
      exp_q.push_back(v.exp_gnt);
      @(posedge clk);
      #1;
      g  = v.sel ? b_gnt : a_gnt;
      vl = v.sel ? b_vld : a_vld;
      to = v.sel ? b_to  : a_to;
      id = v.sel ? b_id  : a_id;
      p  = v.sel ? b_ptr : a_ptr;
      eg = exp_q.pop_front();
      check($sformatf("v%0d gnt", n), 32'(g), 32'(eg));
      check($sformatf("v%0d gnt_vld", n), 32'(vl), 32'(|eg));
      check($sformatf("v%0d timeout", n), 32'(to), 32'(v.exp_to));
      check($sformatf("v%0d ptr", n), 32'(p), 32'(v.exp_ptr));
      if (eg != 4'b0) check($sformatf("v%0d gnt_id", n), 32'(id), 32'(idx_of(eg)));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      a_req = '0; a_done = '0; b_req = '0; b_done = '0;

      // single channel 2, done on the 3rd grant cycle
      add(0, 1, 4'b0100, 4'b0000, 4'b0100, 0, 2'd0);
      add(0, 0, 4'b0100, 4'b0000, 4'b0100, 0, 2'd0);
      add(0, 0, 4'b0100, 4'b0000, 4'b0100, 0, 2'd0);
      add(0, 0, 4'b0100, 4'b0100, 4'b0000, 0, 2'd3);
      add(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd3);
      // all requesting, done after 2 grant cycles: order 0,1,2,3,0
      for (int c = 0; c < 4; c++) begin
         add(0, c == 0, 4'b1111, 4'b0000, 4'(1 << c), 0, 2'(c));
         add(0, 0, 4'b1111, 4'b0000, 4'(1 << c), 0, 2'(c));
         add(0, 0, 4'b1111, 4'(1 << c), 4'b0000, 0, 2'((c + 1) % 4));
      end
      add(0, 0, 4'b1111, 4'b0000, 4'b0001, 0, 2'd0);
      // timeout on channel 1, then regrant after the gap
      for (int c = 0; c < 8; c++) add(0, c == 0, 4'b0010, 4'b0000, 4'b0010, 0, 2'd0);
      add(0, 0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd2);
      add(0, 0, 4'b0010, 4'b0000, 4'b0010, 0, 2'd2);
      add(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2);
      // done collides with the hold limit
      for (int c = 0; c < 8; c++) add(0, c == 0, 4'b0010, 4'b0000, 4'b0010, 0, 2'd0);
      add(0, 0, 4'b0010, 4'b0010, 4'b0000, 0, 2'd2);
      add(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2);
      // back-to-back grants, stray done ignored, abandon release
      add(1, 1, 4'b0011, 4'b0000, 4'b0001, 0, 2'd0);
      add(1, 0, 4'b0011, 4'b1000, 4'b0001, 0, 2'd0);
      add(1, 0, 4'b0011, 4'b1000, 4'b0001, 0, 2'd0);
      add(1, 0, 4'b0011, 4'b0001, 4'b0010, 0, 2'd1);
      add(1, 0, 4'b0011, 4'b0010, 4'b0001, 0, 2'd2);
      add(1, 0, 4'b0010, 4'b0000, 4'b0010, 0, 2'd1);
      add(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2);
      // move ptr to 3 and grant channel 3, for the async reset sequence
      add(0, 1, 4'b0100, 4'b0000, 4'b0100, 0, 2'd0);
      add(0, 0, 4'b0100, 4'b0100, 4'b0000, 0, 2'd3);
      add(0, 0, 4'b1000, 4'b0000, 4'b1000, 0, 2'd3);
      add(0, 0, 4'b1000, 4'b0000, 4'b1000, 0, 2'd3);

      // reset state
      do_reset();
      #1;
      check("rst a_gnt", 32'(a_gnt), 32'h0);
      check("rst a_vld", 32'(a_vld), 32'h0);
      check("rst a_id", 32'(a_id), 32'h0);
      check("rst a_to", 32'(a_to), 32'h0);
      check("rst a_ptr", 32'(a_ptr), 32'h0);
      check("rst b_gnt", 32'(b_gnt), 32'h0);
      check("rst b_ptr", 32'(b_ptr), 32'h0);

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

      // async reset mid-grant (dut_a holds gnt=1000, ptr=3)
      #2;
      rst_n = 1'b0;
      #1;
      check("async gnt", 32'(a_gnt), 32'h0);
      check("async vld", 32'(a_vld), 32'h0);
      check("async to", 32'(a_to), 32'h0);
      check("async ptr", 32'(a_ptr), 32'h0);
      @(negedge clk);
      a_req = 4'b1000;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("regrant gnt", 32'(a_gnt), 32'h8);
      check("regrant id", 32'(a_id), 32'h3);
      check("regrant ptr", 32'(a_ptr), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
